set_bit_scanner: RTL and testbench
==================================

# set_bit_scanner

Sequential set-bit enumerator that sits directly downstream of the combinational 32-bit priority encoder stage. The block accepts one 32-bit word per transaction over a valid/ready handshake and emits the index of every set bit, one index per output beat, from the most significant set bit to the least significant. Each beat carries the word's total set-bit count and a last-beat flag. An all-zero word produces a single "none" beat.

## Interface
- `DATA_W`, 32: input word width. Only 32 is supported.
- `POS_W`, 6: width of the index and count fields, sized to hold values 0..32.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `data_in` holds a word to be scanned.
- `in_ready` output 1: the block can accept a word. High only in IDLE.
- `data_in` input 32: word to scan.
- `out_valid` output 1: `data_out`, `out_count` and `out_last` are valid.
- `out_ready` input 1: the consumer accepts the current beat.
- `data_out` output 6: bit index of the current set bit (0 = LSB). The value 32 means the word had no set bits.
- `out_count` output 6: population count of the accepted word, held constant for all beats of that word.
- `out_last` output 1: the current beat is the final beat of the word.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Internal registers: 32-bit `work`, 6-bit `count`, and a state register with states IDLE, EMIT, ZERO.
- **IDLE**
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid && in_ready`: `work` <= `data_in` and `count` <= popcount(`data_in`).
  - Next state is ZERO if `data_in` == 0, otherwise EMIT.
- **EMIT**
  - `out_valid` = 1.
  - `data_out` = index of the highest set bit of `work`, decoded combinationally from the registered `work`.
  - `out_last` = 1 when `work` has exactly one set bit.
  - On `out_valid && out_ready`: clear that bit in `work`. If `out_last` is set, return to IDLE; otherwise stay in EMIT.
- **ZERO**
  - `out_valid` = 1, `data_out` = 32, `out_count` = 0, `out_last` = 1.
  - On `out_ready`: return to IDLE.
- Stall: while `out_valid && !out_ready`, every output holds its value unchanged.
- No overlap between words: `in_ready` = 0 in EMIT and ZERO, and `data_in` is ignored in those states.
- Arithmetic:
  - popcount is a 6-bit unsigned sum with range 0..32.
  - A word with all 32 bits set gives `out_count` = 32 and 32 beats, indices 31 down to 0.
- `out_count` and `data_out` are don't-care while `out_valid` = 0. Drive them as 0.

## Timing
- Reset (asynchronous assert, takes effect immediately without a clock edge):
  - State = IDLE, `work` = 0, `count` = 0.
  - `out_valid` = 0, `out_last` = 0, `data_out` = 0, `out_count` = 0, `busy` = 0.
  - `in_ready` = 1 once reset is released.
  - A reset asserted mid-word discards the remaining beats. No further beat of that word appears after reset.
- Latency: a word accepted on rising edge N presents its first beat (`out_valid` = 1) in the cycle after edge N.
- Throughput:
  - With `out_ready` held high, a word with k set bits takes k beats on consecutive cycles.
  - It is followed by exactly one IDLE cycle before the next word can be accepted, so the per-word period is k+1 cycles, or 2 cycles for a zero word.
- Handshake:
  - A beat transfers only on an edge where both `out_valid` and `out_ready` are high.
  - `out_valid` never drops without a transfer, except under reset.
  - `in_ready` is registered state, not combinationally dependent on `out_ready`.
- `busy` rises in the cycle after acceptance and falls in the cycle after the last beat transfers.

## Test plan
- Reset and zero word:
  - Assert `rst`, then release it; check all outputs are 0 and `in_ready` = 1.
  - Send 0x00000000 -> one beat with `data_out` = 32, `out_count` = 0, `out_last` = 1, then `in_ready` = 1 again.
- Single-bit words, one transaction each:
  - 0x80000000 -> one beat, `data_out` = 31, `out_count` = 1, `out_last` = 1.
  - 0x00000001 -> one beat, `data_out` = 0.
  - 0x00008000 -> one beat, `data_out` = 15.
- Multi-bit word 0x30000002 with `out_ready` held high -> beats 29, 28, 1 on consecutive cycles, each with `out_count` = 3. Only the beat 1 has `out_last` = 1. Total word period is 4 cycles.
- Backpressure: send 0x00000005 and hold `out_ready` low for 3 cycles -> `data_out` stays 2 and `out_valid` stays 1 throughout. Release `out_ready` -> beats 2 then 0.
- Full word 0xFFFFFFFF -> 32 beats with indices 31 down to 0, `out_count` = 32 on every beat, and `out_last` only on index 0.
- Mid-operation reset: send 0xF0000000, accept 2 beats (31, 30), then pulse `rst` -> `out_valid` = 0 immediately. Send 0x00000010 -> a single beat 4 with `out_count` = 1, and no stale indices 29 or 28 appear.

Source files
------------

// File: rtl/set_bit_scanner.sv
// Set-bit enumerator: accepts one word per handshake and emits the index of
// every set bit, MSB first, with the word's popcount and a last-beat flag.
module set_bit_scanner #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned POS_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POS_W-1:0]  data_out,
    output logic [POS_W-1:0]  out_count,
    output logic              out_last,
    output logic              busy
);

    localparam logic [POS_W-1:0] NONE_IDX = POS_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ZERO = 2'd2
    } state_e;

    function automatic logic [POS_W-1:0] popcnt(input logic [DATA_W-1:0] w);
        logic [POS_W-1:0] s;
        s = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            s = s + POS_W'(w[i]);
        end
        return s;
    endfunction

    function automatic logic [POS_W-1:0] msb_idx(input logic [DATA_W-1:0] w);
        logic [POS_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (w[i]) idx = POS_W'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [DATA_W-1:0] w);
        return (w != '0) && ((w & (w - DATA_W'(1))) == '0);
    endfunction

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic [POS_W-1:0]    count_q, count_d;
    logic [POS_W-1:0]    idx_q, idx_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   work_nx;

    // Beat fields are precomputed one cycle ahead so every output is a flop.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        work_nx = work_q & ~(DATA_W'(1) << idx_q);

        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    work_d  = data_in;
                    count_d = popcnt(data_in);
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    if (data_in == '0) begin
                        state_d = ZERO;
                        idx_d   = NONE_IDX;
                        last_d  = 1'b1;
                    end else begin
                        state_d = EMIT;
                        idx_d   = msb_idx(data_in);
                        last_d  = single_bit(data_in);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    work_d = work_nx;
                    if (last_q) begin
                        state_d = IDLE;
                        count_d = '0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d  = msb_idx(work_nx);
                        last_d = single_bit(work_nx);
                    end
                end
            end
            ZERO: begin
                if (out_ready) begin
                    state_d = IDLE;
                    work_d  = '0;
                    count_d = '0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                work_d  = '0;
                count_d = '0;
                idx_d   = '0;
                last_d  = 1'b0;
                valid_d = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign data_out  = idx_q;
    assign out_count = count_q;
    assign out_last  = last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_set_bit_scanner.sv
// Bench for set_bit_scanner: directed and random words checked against a
// list-of-indices reference model, with random output backpressure.
module tb_set_bit_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  data_out;
    logic [5:0]  out_count;
    logic        out_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    set_bit_scanner #(.DATA_W(32), .POS_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_count (out_count),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_data_out"},  32'(data_out),  32'd0);
        check({tag, "_out_count"}, 32'(out_count), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Send one word and consume its beats; stop_after < 0 drains the whole word.
    task automatic send_word(input logic [31:0] w, input int stall_pct, input int stop_after);
        int exp_idx[$];
        int exp_cnt;
        int guard;
        int n;
        int stalls;
        for (int i = 31; i >= 0; i--) begin
            if (w[i]) exp_idx.push_back(i);
        end
        exp_cnt = exp_idx.size();
        if (exp_cnt == 0) exp_idx.push_back(32);

        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        data_in   = w;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = $urandom;
        check("in_ready_low_after_accept", 32'(in_ready), 32'd0);
        check("busy_after_accept", 32'(busy), 32'd1);

        n = 0;
        stalls = 0;
        while (n < exp_idx.size() && n != stop_after) begin
            check("out_valid_beat", 32'(out_valid), 32'd1);
            if (out_valid !== 1'b1) break;
            check("data_out", 32'(data_out), 32'(exp_idx[n]));
            check("out_count", 32'(out_count), 32'(exp_cnt));
            check("out_last", 32'(out_last), 32'(n == exp_idx.size() - 1));
            out_ready = (stalls >= 3) || ($urandom_range(99) >= stall_pct);
            if (out_ready) begin
                n++;
                stalls = 0;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        if (n == exp_idx.size()) begin
            check("in_ready_after_last", 32'(in_ready), 32'd1);
            check_idle_outputs("after_last");
        end
    endtask

    initial begin
        logic [31:0] w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check_idle_outputs("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        check_idle_outputs("after_reset");

        // Zero word, single-bit words, multi-bit word, backpressure, full word
        send_word(32'h0000_0000, 0, -1);
        send_word(32'h8000_0000, 0, -1);
        send_word(32'h0000_0001, 0, -1);
        send_word(32'h0000_8000, 0, -1);
        send_word(32'h3000_0002, 0, -1);
        send_word(32'h0000_0005, 100, -1);
        send_word(32'hFFFF_FFFF, 0, -1);

        // Reset in the middle of a word discards the remaining beats
        send_word(32'hF000_0000, 0, 2);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
        check_idle_outputs("after_mid_reset");
        send_word(32'h0000_0010, 0, -1);

        // Random words of varying density with random backpressure
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(3))
                0: w = $urandom;
                1: w = $urandom & $urandom & $urandom;
                2: begin
                    w = 32'd1;
                    w = w << $urandom_range(31);
                end
                default: w = ($urandom_range(1) == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
            endcase
            send_word(w, int'($urandom_range(50)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
